// File: rtl/fwd_bypass_unit_pkg.sv
// Shared select codes and the retired-write history entry layout for the
// operand-forwarding block.
package fwd_bypass_unit_pkg;

  localparam int SEL_RF    = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;
  localparam int SEL_HIST0 = 3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  // Entry layout at the core's native widths; the top level mirrors this
  // layout with its own parameterised widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_operand_sel.sv
// Resolves one source operand: youngest matching producer wins, register 0
// always reads the register file.
module fwd_operand_sel
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int SEL_W      = $clog2(3 + HIST_DEPTH)
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic                         exmem_wen,
  input  logic [REG_AW-1:0]            exmem_rd,
  input  logic [DATA_W-1:0]            exmem_data,
  input  logic                         memwb_wen,
  input  logic [REG_AW-1:0]            memwb_rd,
  input  logic [DATA_W-1:0]            memwb_data,
  input  logic [HIST_DEPTH-1:0]        hist_valid,
  input  logic [HIST_DEPTH*REG_AW-1:0] hist_rd,
  input  logic [HIST_DEPTH*DATA_W-1:0] hist_data,
  output logic [DATA_W-1:0]            data,
  output logic [SEL_W-1:0]             sel
);

  always_comb begin
    data = rf_data;
    sel  = SEL_W'(SEL_RF);
    if (rs != '0) begin
      // NOTE: blocking assignments in combinational logic; each later match
      // overrides the earlier one, so candidates are visited oldest first.
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        if (hist_valid[k] && (hist_rd[k*REG_AW +: REG_AW] == rs)) begin
          data = hist_data[k*DATA_W +: DATA_W];
          sel  = SEL_W'(SEL_HIST0 + k);
        end
      end
      if (memwb_wen && (memwb_rd == rs)) begin
        data = memwb_data;
        sel  = SEL_W'(SEL_MEMWB);
      end
      if (exmem_wen && (exmem_rd == rs)) begin
        data = exmem_data;
        sel  = SEL_W'(SEL_EXMEM);
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: retired-write history, per-operand resolution and
// load-use stall generation for the operand stage.
module fwd_bypass_unit
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(3 + HIST_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
  input  logic                      exmem_wen,
  input  logic                      exmem_is_load,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic [DATA_W-1:0]         exmem_data,
  input  logic                      memwb_wen,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic [DATA_W-1:0]         memwb_data,
  input  logic                      hist_clr,
  output logic [NUM_SRC*DATA_W-1:0] opnd_data,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

  logic [HIST_DEPTH-1:0]        hist_valid;
  logic [HIST_DEPTH*REG_AW-1:0] hist_rd;
  logic [HIST_DEPTH*DATA_W-1:0] hist_data;
  logic [CNT_W-1:0]             stall_cnt;
  logic                         load_hz;

  // Entry k holds the write retired k+1 cycles ago; it ages even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= '0;
    end else if (hist_clr) begin
      hist_valid <= '0;
    end else begin
      for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
        hist_valid[k] <= hist_valid[k-1];
      end
      hist_valid[0] <= memwb_wen && (memwb_rd != '0);
    end
  end

  // NOTE: payload fields carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
      hist_rd[k*REG_AW +: REG_AW]   <= hist_rd[(k-1)*REG_AW +: REG_AW];
      hist_data[k*DATA_W +: DATA_W] <= hist_data[(k-1)*DATA_W +: DATA_W];
    end
    hist_rd[0 +: REG_AW]   <= memwb_rd;
    hist_data[0 +: DATA_W] <= memwb_data;
  end

  always_comb begin
    load_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exmem_rd == id_rs[i*REG_AW +: REG_AW]) load_hz = 1'b1;
    end
    load_hz = load_hz && id_valid && exmem_wen && exmem_is_load && (exmem_rd != '0);
  end

  assign stall = load_hz || (stall_cnt != '0);

  // A hazard seen mid-stall does not reload the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((stall_cnt == '0) && load_hz) begin
      stall_cnt <= CNT_W'(LOAD_LAT - 1);
    end else if (stall_cnt != '0) begin
      stall_cnt <= stall_cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_opnd
    fwd_operand_sel #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .HIST_DEPTH (HIST_DEPTH),
      .SEL_W      (SEL_W)
    ) u_sel (
      .rs         (id_rs[i*REG_AW +: REG_AW]),
      .rf_data    (rf_rdata[i*DATA_W +: DATA_W]),
      .exmem_wen  (exmem_wen),
      .exmem_rd   (exmem_rd),
      .exmem_data (exmem_data),
      .memwb_wen  (memwb_wen),
      .memwb_rd   (memwb_rd),
      .memwb_data (memwb_data),
      .hist_valid (hist_valid),
      .hist_rd    (hist_rd),
      .hist_data  (hist_data),
      .data       (opnd_data[i*DATA_W +: DATA_W]),
      .sel        (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

endmodule

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding block for the pipelined RISC core; generalises the fixed three-input forwarding mux.
- Resolves NUM_SRC source operands for the instruction in the operand stage. Candidate sources: EX/MEM result, MEM/WB result, a HIST_DEPTH-deep history of recently retired writes, and the register-file read data.
- Generates load-use stalls lasting LOAD_LAT cycles.
- Sits between the register file / pipeline registers and the EX-stage ALU inputs.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands resolved per cycle
- HIST_DEPTH, 2, retired-write history entries (≥1)
- LOAD_LAT, 1, load-use stall length in cycles (≥1)
- SEL_W, $clog2(3+HIST_DEPTH), width of per-operand select code

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  operand-stage instruction valid
- id_rs  in  NUM_SRC*REG_AW  source register addresses, operand i at [i*REG_AW +: REG_AW]
- rf_rdata  in  NUM_SRC*DATA_W  register-file read data per operand
- exmem_wen  in  1  EX/MEM writes a register
- exmem_is_load  in  1  EX/MEM instruction is a load
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_data  in  DATA_W  EX/MEM result
- memwb_wen  in  1  MEM/WB writes a register
- memwb_rd  in  REG_AW  MEM/WB destination
- memwb_data  in  DATA_W  MEM/WB result
- hist_clr  in  1  synchronous history invalidate (pipeline flush)
- opnd_data  out  NUM_SRC*DATA_W  resolved operands
- fwd_sel  out  NUM_SRC*SEL_W  per-operand source: 0=rf, 1=EX/MEM, 2=MEM/WB, 3+k=history entry k
- stall  out  1  hold operand stage and earlier stages

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset clears all history valid bits and stall_cnt. Consequences:
  - stall=0.
  - fwd_sel=0 and opnd_data=rf_rdata, assuming no exmem/memwb matches.
- History:
  - hist[0..HIST_DEPTH-1] holds {valid, rd, data}.
  - Every rising edge, shift: hist[k] <= hist[k-1], and hist[0] <= {memwb_wen && memwb_rd!=0, memwb_rd, memwb_data}.
  - The history shifts every cycle, including stall cycles, so entry k is the write retired k+1 cycles ago.
  - hist_clr=1 clears all valid bits on that edge; the shift-in is suppressed in the same cycle.
- Operand resolution is combinational, zero-cycle latency. For each operand i with rs=id_rs[i], priority is youngest first:
  1. exmem_wen && exmem_rd==rs && rs!=0 -> exmem_data, sel 1
  2. memwb_wen && memwb_rd==rs && rs!=0 -> memwb_data, sel 2
  3. lowest k with hist[k].valid && hist[k].rd==rs -> hist[k].data, sel 3+k
  4. otherwise rf_rdata[i], sel 0
- Register 0 is never forwarded; it always takes sel 0.
- Resolution is independent of id_valid. Outputs are don't-care when id_valid=0, but must still follow the rules above.
- Load-use hazard: load_hz = id_valid && exmem_wen && exmem_is_load && exmem_rd!=0 && (exmem_rd matches any id_rs[i]).
- Stall counter stall_cnt, width $clog2(LOAD_LAT+1):
  - stall = load_hz || (stall_cnt!=0).
  - If stall_cnt==0 && load_hz: stall_cnt <= LOAD_LAT-1.
  - Else if stall_cnt!=0: stall_cnt <= stall_cnt-1.
  - A load_hz during a counted stall does not reload the counter.
- With LOAD_LAT=1, the stall is exactly one cycle. The bubble lets the load result move to MEM/WB, where it is forwarded with sel 2.
- While stall=1, opnd_data still reflects current resolution. Downstream must insert a bubble; this block does not gate it.
- Simultaneous hist_clr and load_hz: the stall still asserts; flush handling belongs to the pipeline controller.
- Reset mid-stall: stall drops immediately (asynchronous) and the history empties.

Decomposition:
- Shared package holds the SEL_RF/SEL_EXMEM/SEL_MEMWB/SEL_HIST0 constants and a hist_entry_t struct {valid, rd, data}.
- One sub-module: fwd_operand_sel. It resolves one operand (priority compare and mux) and is instantiated NUM_SRC times via generate.
- History shift register and stall FSM stay in the top level.

Test Plan:
- Reset: rst_n=0 with rf_rdata={0x11,0x22} -> opnd_data={0x11,0x22}, fwd_sel={0,0}, stall=0. After release, the same holds until a write occurs.
- EX/MEM priority: exmem rd=5 data=0xAAAA and memwb rd=5 data=0xBBBB, id_rs={5,6} -> operand0=0xAAAA sel 1; operand1=rf sel 0.
- History aging (HIST_DEPTH=2): memwb writes rd=7 data=0xC0DE in cycle 0 and nothing after. id_rs0=7 -> sel 3 in cycle 1, sel 4 in cycle 2, sel 0 in cycle 3. hist_clr in cycle 1 -> sel 0 from cycle 2.
- Register 0: exmem rd=0 wen=1 data=0xFFFF, id_rs0=0, rf_rdata=0 -> opnd=0, sel 0, and no stall even if exmem_is_load=1.
- Load-use (LOAD_LAT=1): load rd=3 in EX/MEM, id_rs1=3 -> stall=1 for one cycle. Next cycle memwb rd=3 data=0x1234 -> operand1=0x1234 sel 2, stall=0.
- LOAD_LAT=3: the same hazard gives stall high exactly 3 cycles. Asserting rst_n=0 in the second cycle drops stall immediately, and all history valid bits read 0.
